// File: rtl/tpu_acc_pkg.sv
// Shared types and default sizing for the K-tiled accumulator sequencer.
package tpu_acc_pkg;

    localparam int unsigned ACC_MAX_K     = 16;
    localparam int unsigned ACC_MAX_ROWS  = 256;
    localparam int unsigned ACC_ALIGN_LAT = 2;
    localparam int unsigned ACC_KW        = $clog2(ACC_MAX_K + 1);
    localparam int unsigned ACC_RW        = $clog2(ACC_MAX_ROWS + 1);

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        FILL,
        GAP,
        DONE
    } acc_ctrl_state_e;

    typedef struct packed {
        logic [ACC_KW-1:0] k;
        logic [ACC_RW-1:0] rows;
    } acc_job_t;

endpackage

// File: rtl/acc_buf_tracker.sv
// Full/empty bookkeeping for the two accumulator buffers; a same-cycle set beats a release.
module acc_buf_tracker (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       set_en,
    input  logic       set_id,
    input  logic       rel_en,
    input  logic       rel_id,
    output logic [1:0] buf_full,
    output logic [1:0] buf_full_nxt_c,
    output logic       err_c
);

    always_comb begin
        buf_full_nxt_c = buf_full;
        if (rel_en) buf_full_nxt_c[rel_id] = 1'b0;
        if (set_en) buf_full_nxt_c[set_id] = 1'b1;
    end

    // Releasing an empty buffer, or racing the completion of that same buffer.
    assign err_c = rel_en && (!buf_full[rel_id] || (set_en && (set_id == rel_id)));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            buf_full <= 2'b00;
        end else begin
            buf_full <= buf_full_nxt_c;
        end
    end

endmodule

// File: rtl/accumulator_ctrl.sv
// Multi-pass accumulator sequencer with double-buffered output.
// Optional ACC_CTRL_PERF_EN adds busy/stall performance counters.
module accumulator_ctrl
    import tpu_acc_pkg::*;
#(
    parameter int unsigned MAX_K     = ACC_MAX_K,
    parameter int unsigned MAX_ROWS  = ACC_MAX_ROWS,
    parameter int unsigned ALIGN_LAT = ACC_ALIGN_LAT,
    localparam int unsigned KW       = $clog2(MAX_K + 1),
    localparam int unsigned RW       = $clog2(MAX_ROWS + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic [KW-1:0] cmd_k_passes,
    input  logic [RW-1:0] cmd_rows,
    output logic          mmu_start,
    input  logic          mmu_valid,
    output logic          acc_valid_in,
    output logic          acc_accumulate,
    output logic          acc_addr_sel,
    output logic          buf_done,
    output logic          buf_done_id,
    input  logic          buf_release,
    input  logic          buf_release_id,
    output logic          busy,
    output logic          err
`ifdef ACC_CTRL_PERF_EN
    ,
    output logic [31:0]   perf_busy_cycles,
    output logic [31:0]   perf_stall_cycles
`endif
);

    localparam int unsigned GW = (ALIGN_LAT > 1) ? $clog2(ALIGN_LAT) : 1;

    acc_ctrl_state_e state_q, state_nxt;
    acc_job_t        job_q, job_nxt;
    logic [KW-1:0]   pass_cnt_q, pass_cnt_nxt;
    logic [RW-1:0]   row_cnt_q, row_cnt_nxt;
    logic [GW-1:0]   gap_cnt_q, gap_cnt_nxt;
    logic            sel_nxt;
    logic            err_nxt;
    logic            accept_c;
    logic            set_en_c;
    logic [1:0]      buf_full;
    logic [1:0]      buf_full_nxt_c;
    logic            trk_err_c;

    assign accept_c     = cmd_valid && cmd_ready;
    assign set_en_c     = (state_q == DONE);
    // Beats are only forwarded while a pass is actually filling.
    assign acc_valid_in = mmu_valid && (state_q == FILL);

    acc_buf_tracker u_buf_tracker (
        .clk            (clk),
        .rst_n          (rst_n),
        .set_en         (set_en_c),
        .set_id         (acc_addr_sel),
        .rel_en         (buf_release),
        .rel_id         (buf_release_id),
        .buf_full       (buf_full),
        .buf_full_nxt_c (buf_full_nxt_c),
        .err_c          (trk_err_c)
    );

    always_comb begin
        state_nxt    = state_q;
        job_nxt      = job_q;
        pass_cnt_nxt = pass_cnt_q;
        row_cnt_nxt  = row_cnt_q;
        gap_cnt_nxt  = gap_cnt_q;
        sel_nxt      = acc_addr_sel;
        err_nxt      = err || trk_err_c;

        if (mmu_valid && (state_q != FILL)) err_nxt = 1'b1;

        unique case (state_q)
            IDLE: begin
                if (accept_c) begin
                    job_nxt.k    = ACC_KW'(cmd_k_passes);
                    job_nxt.rows = ACC_RW'(cmd_rows);
                    pass_cnt_nxt = '0;
                    row_cnt_nxt  = '0;
                    // Degenerate jobs are swallowed and flagged.
                    if ((cmd_k_passes == '0) || (cmd_rows == '0)) begin
                        err_nxt = 1'b1;
                    end else begin
                        state_nxt = ISSUE;
                    end
                end
            end
            ISSUE: state_nxt = FILL;
            FILL: begin
                if (mmu_valid) begin
                    if (row_cnt_q == RW'(job_q.rows - 1'b1)) begin
                        row_cnt_nxt = '0;
                        gap_cnt_nxt = '0;
                        state_nxt   = GAP;
                    end else begin
                        row_cnt_nxt = row_cnt_q + 1'b1;
                    end
                end
            end
            GAP: begin
                // Controls stay frozen until the align skew has flushed the last beat.
                if (gap_cnt_q == GW'(ALIGN_LAT - 1)) begin
                    if (pass_cnt_q == KW'(job_q.k - 1'b1)) begin
                        state_nxt = DONE;
                    end else begin
                        pass_cnt_nxt = pass_cnt_q + 1'b1;
                        state_nxt    = ISSUE;
                    end
                end else begin
                    gap_cnt_nxt = gap_cnt_q + 1'b1;
                end
            end
            DONE: begin
                state_nxt    = IDLE;
                sel_nxt      = ~acc_addr_sel;
                pass_cnt_nxt = '0;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            job_q          <= '0;
            pass_cnt_q     <= '0;
            row_cnt_q      <= '0;
            gap_cnt_q      <= '0;
            acc_addr_sel   <= 1'b0;
            err            <= 1'b0;
            cmd_ready      <= 1'b0;
            mmu_start      <= 1'b0;
            acc_accumulate <= 1'b0;
            buf_done       <= 1'b0;
            buf_done_id    <= 1'b0;
            busy           <= 1'b0;
        end else begin
            state_q        <= state_nxt;
            job_q          <= job_nxt;
            pass_cnt_q     <= pass_cnt_nxt;
            row_cnt_q      <= row_cnt_nxt;
            gap_cnt_q      <= gap_cnt_nxt;
            acc_addr_sel   <= sel_nxt;
            err            <= err_nxt;
            cmd_ready      <= (state_nxt == IDLE) && !buf_full_nxt_c[sel_nxt];
            mmu_start      <= (state_nxt == ISSUE);
            acc_accumulate <= (pass_cnt_nxt != '0);
            buf_done       <= (state_nxt == DONE);
            buf_done_id    <= (state_nxt == DONE) && sel_nxt;
            busy           <= (state_nxt != IDLE);
        end
    end

`ifdef ACC_CTRL_PERF_EN
    // Saturating activity counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_busy_cycles  <= 32'd0;
            perf_stall_cycles <= 32'd0;
        end else begin
            if (busy && (perf_busy_cycles != 32'hFFFF_FFFF)) begin
                perf_busy_cycles <= perf_busy_cycles + 32'd1;
            end
            if (cmd_valid && !cmd_ready && (perf_stall_cycles != 32'hFFFF_FFFF)) begin
                perf_stall_cycles <= perf_stall_cycles + 32'd1;
            end
        end
    end
`endif

endmodule
